// File: rtl/vec_exe_sequencer.sv
// Vector execute sequencer: steps one vector ALU instruction over its elements through the
// shared scalar ALU, one element per cycle, into a 1-entry valid/ready writeback buffer.
module vec_exe_sequencer #(
  parameter int MAX_VL = 8,
  parameter int VL_W   = 4,
  parameter int EL_W   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [VL_W-1:0] issue_vl,
  input  logic [4:0]      issue_rd,
  input  logic [5:0]      issue_funct,
  input  logic [1:0]      issue_aluop,
  input  logic            issue_alusrc,
  input  logic [4:0]      issue_shamt,
  output logic [5:0]      alu_funct,
  output logic [1:0]      alu_aluop,
  output logic            alu_alusrc,
  output logic [4:0]      alu_shamt,
  output logic [EL_W-1:0] elem_idx,
  input  logic [31:0]     alu_result,
  input  logic            alu_overflow,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_addr,
  output logic [EL_W-1:0] wb_elem,
  output logic [31:0]     wb_data,
  output logic            busy,
  output logic            done,
  output logic            ovf_sticky
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t          state;
  logic [EL_W-1:0] last_idx;
  logic [VL_W-1:0] vl_eff;
  logic            cap;
  logic            pop;

  // NOTE: every signal driven from always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    vl_eff = (issue_vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : issue_vl;
    cap    = (state == RUN) && (!wb_valid || wb_ready);
    pop    = wb_valid && wb_ready;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_idx    <= '0;
      elem_idx    <= '0;
      alu_funct   <= '0;
      alu_aluop   <= '0;
      alu_alusrc  <= 1'b0;
      alu_shamt   <= '0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_elem     <= '0;
      wb_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf_sticky  <= 1'b0;
      issue_ready <= 1'b1;
    end else begin
      done <= 1'b0;

      // A pop with a same-edge capture keeps the buffer full: old entry leaves, new one loads.
      if (pop && !cap) wb_valid <= 1'b0;
      if (cap) begin
        wb_data    <= alu_result;
        wb_elem    <= elem_idx;
        wb_valid   <= 1'b1;
        ovf_sticky <= ovf_sticky | alu_overflow;
      end

      case (state)
        IDLE: begin
          if (issue_valid) begin
            alu_funct   <= issue_funct;
            alu_aluop   <= issue_aluop;
            alu_alusrc  <= issue_alusrc;
            alu_shamt   <= issue_shamt;
            wb_addr     <= issue_rd;
            last_idx    <= EL_W'(vl_eff - VL_W'(1));
            elem_idx    <= '0;
            ovf_sticky  <= 1'b0;
            busy        <= 1'b1;
            issue_ready <= 1'b0;
            if (vl_eff == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (cap) begin
            if (elem_idx == last_idx) state <= DRAIN;
            else                      elem_idx <= elem_idx + EL_W'(1);
          end
        end
        DRAIN: begin
          if (pop) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state       <= IDLE;
          busy        <= 1'b0;
          issue_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
